// File: rtl/vco_pkg.sv
// Shared definitions for the multi-band VCO control slice: state encoding,
// default parameter values and the band-enable one-hot helper.
package vco_pkg;

  localparam int unsigned DEF_NUM_BANDS     = 4;
  localparam int unsigned DEF_BREAK_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 256;
  localparam int unsigned DEF_MEAS_CYCLES   = 1024;
  localparam int unsigned DEF_CNT_W         = 16;

  // Widest band-enable vector the helper can produce; callers size-cast down.
  localparam int unsigned MAX_BANDS = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BREAK   = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_MEASURE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    BREAK   = ST_BREAK,
    SETTLE  = ST_SETTLE,
    MEASURE = ST_MEASURE
  } state_e;

  function automatic logic [MAX_BANDS-1:0] onehot(input int unsigned idx);
    logic [MAX_BANDS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_BANDS; i++) begin
      v[i] = (i == idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/vco_edge_counter.sv
// Synchronises the divided VCO output, detects rising edges and counts them
// into a saturating counter under clear/enable control.
module vco_edge_counter
  import vco_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vco_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic             rise;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && rise && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // The next-state value is exported so the final window cycle's edge is
  // included when the sequencer latches the result on that same clock.
  assign count_o = count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= vco_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vco_band_sequencer.sv
// Band select sequencer for the multi-band VCO: break-before-make switching of
// the control-voltage channels, settle wait, then a gated frequency count.
module vco_band_sequencer
  import vco_pkg::*;
#(
  parameter int unsigned NUM_BANDS     = DEF_NUM_BANDS,
  parameter int unsigned SEL_W         = $clog2(NUM_BANDS),
  parameter int unsigned BREAK_CYCLES  = DEF_BREAK_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MEAS_CYCLES   = DEF_MEAS_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                 user_clock2,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     band_req,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 meas_req,
  input  logic                 vco_in,
  output logic [NUM_BANDS-1:0] band_en,
  output logic [SEL_W-1:0]     cur_band,
  output logic                 busy,
  output logic [CNT_W-1:0]     meas_count,
  output logic                 meas_valid,
  output logic                 err
);

  localparam int unsigned TMR_MAX_A = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > MEAS_CYCLES) ? TMR_MAX_A : MEAS_CYCLES;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]     BREAK_LOAD  = TMR_W'(BREAK_CYCLES - 1);
  localparam logic [TMR_W-1:0]     SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]     MEAS_LOAD   = TMR_W'(MEAS_CYCLES - 1);
  localparam logic [NUM_BANDS-1:0] BAND0_EN    = NUM_BANDS'(onehot(0));

  state_e               state_q, state_d;
  logic [NUM_BANDS-1:0] band_en_q, band_en_d;
  logic [SEL_W-1:0]     cur_band_q, cur_band_d;
  logic [SEL_W-1:0]     target_q, target_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     meas_count_q, meas_count_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 err_q, err_d;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_W-1:0]     cnt_val;
  logic                 req_legal;

  assign req_legal = (32'(band_req) < NUM_BANDS);
  assign cnt_en    = (state_q == MEASURE);

  vco_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk_i   (user_clock2),
    .rst_ni  (rst_n),
    .vco_i   (vco_in),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt_val)
  );

  always_comb begin
    state_d      = state_q;
    band_en_d    = band_en_q;
    cur_band_d   = cur_band_q;
    target_d     = target_q;
    timer_d      = timer_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    cnt_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        // A band request outranks meas_req: every switch ends in a measurement.
        if (req_valid) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (band_req != cur_band_q) begin
            state_d   = BREAK;
            band_en_d = '0;
            target_d  = band_req;
            timer_d   = BREAK_LOAD;
          end else begin
            state_d = SETTLE;
            timer_d = SETTLE_LOAD;
          end
        end else if (meas_req) begin
          state_d = MEASURE;
          timer_d = MEAS_LOAD;
          cnt_clr = 1'b1;
        end
      end
      BREAK: begin
        if (timer_q == '0) begin
          state_d    = SETTLE;
          band_en_d  = NUM_BANDS'(onehot(32'(target_q)));
          cur_band_d = target_q;
          timer_d    = SETTLE_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = MEASURE;
          timer_d = MEAS_LOAD;
          cnt_clr = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEASURE: begin
        if (timer_q == '0) begin
          state_d      = IDLE;
          meas_count_d = cnt_val;
          meas_valid_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clock2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      band_en_q    <= BAND0_EN;
      cur_band_q   <= '0;
      target_q     <= '0;
      timer_q      <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      band_en_q    <= band_en_d;
      cur_band_q   <= cur_band_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign band_en    = band_en_q;
  assign cur_band   = cur_band_q;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vco_band_sequencer.sv
// Directed bench for vco_band_sequencer with five bands and an 8-bit counter.
module tb_vco_band_sequencer;

  localparam int unsigned NB = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] band_req = '0;
  logic          req_valid = 1'b0;
  logic          meas_req = 1'b0;
  logic          vco_in = 1'b0;
  logic          req_ready;
  logic [NB-1:0] band_en;
  logic [SW-1:0] cur_band;
  logic          busy;
  logic [CW-1:0] meas_count;
  logic          meas_valid;
  logic          err;

  int tests = 0;
  int fails = 0;
  int vco_half = 0;

  vco_band_sequencer #(
    .NUM_BANDS     (NB),
    .BREAK_CYCLES  (4),
    .SETTLE_CYCLES (256),
    .MEAS_CYCLES   (1024),
    .CNT_W         (CW)
  ) dut (
    .user_clock2 (clk),
    .rst_n       (rst_n),
    .band_req    (band_req),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .meas_req    (meas_req),
    .vco_in      (vco_in),
    .band_en     (band_en),
    .cur_band    (cur_band),
    .busy        (busy),
    .meas_count  (meas_count),
    .meas_valid  (meas_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  // vco_half is the half-period of vco_in in clock cycles; 0 holds the level.
  always begin
    if (vco_half == 0) begin
      #7;
    end else begin
      #(vco_half * 10);
      vco_in = ~vco_in;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic accept(input logic [SW-1:0] b, input logic rv, input logic mr);
    band_req  = b;
    req_valid = rv;
    meas_req  = mr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    meas_req  = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (meas_valid || err) pulses++;
    end
    tests++; if (band_en !== 5'b00001) begin fails++; $display("FAIL reset_band_en: got %b expected 00001", band_en); end
    tests++; if (cur_band !== 3'd0) begin fails++; $display("FAIL reset_cur_band: got %0d expected 0", cur_band); end
    tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", req_ready, busy); end
    tests++; if (meas_count !== 8'd0) begin fails++; $display("FAIL reset_meas_count: got %0d expected 0", meas_count); end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL reset_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_switch_band2();
    int mv_n;
    int brk_bad;
    logic [NB-1:0] make_en;
    logic [SW-1:0] make_band;
    logic          busy1;
    vco_half = 4;
    mv_n = 0;
    brk_bad = 0;
    make_en = '0;
    make_band = '0;
    busy1 = 1'b0;
    accept(3'd2, 1'b1, 1'b0);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy;
      if (n <= 4 && band_en !== 5'b00000) brk_bad++;
      if (n == 5) begin make_en = band_en; make_band = cur_band; end
      if (meas_valid) begin mv_n = n; break; end
    end
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL switch_busy: got %b expected 1", busy1); end
    tests++; if (brk_bad !== 0) begin fails++; $display("FAIL switch_break: got %0d nonzero break cycles expected 0", brk_bad); end
    tests++; if (make_en !== 5'b00100) begin fails++; $display("FAIL switch_make_en: got %b expected 00100", make_en); end
    tests++; if (make_band !== 3'd2) begin fails++; $display("FAIL switch_cur_band: got %0d expected 2", make_band); end
    tests++; if (mv_n !== 1285) begin fails++; $display("FAIL switch_latency: got %0d expected 1285", mv_n); end
    tests++; if (meas_count < 8'd127 || meas_count > 8'd129) begin fails++; $display("FAIL switch_count: got %0d expected 128+-1", meas_count); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL switch_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL switch_valid_pulse: got %b expected 0", meas_valid); end
  endtask

  task automatic test_same_band();
    int mv_n;
    logic [NB-1:0] en1;
    mv_n = 0;
    en1 = '0;
    accept(3'd2, 1'b1, 1'b0);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 1) en1 = band_en;
      if (meas_valid) begin mv_n = n; break; end
    end
    tests++; if (en1 !== 5'b00100) begin fails++; $display("FAIL same_band_en: got %b expected 00100", en1); end
    tests++; if (mv_n !== 1281) begin fails++; $display("FAIL same_band_latency: got %0d expected 1281", mv_n); end
    tests++; if (meas_count < 8'd127 || meas_count > 8'd129) begin fails++; $display("FAIL same_band_count: got %0d expected 128+-1", meas_count); end
  endtask

  task automatic test_illegal();
    accept(3'd5, 1'b1, 1'b0);
    @(negedge clk);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b expected 1", err); end
    tests++; if (band_en !== 5'b00100 || cur_band !== 3'd2) begin fails++; $display("FAIL illegal_band: got en=%b cur=%0d expected 00100/2", band_en, cur_band); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready: got %b expected 1", req_ready); end
    @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL illegal_err_pulse: got %b expected 0", err); end
  endtask

  task automatic test_req_and_meas();
    int pulses;
    logic [NB-1:0] en1;
    pulses = 0;
    en1 = '1;
    accept(3'd3, 1'b1, 1'b1);
    for (int n = 1; n <= 1500; n++) begin
      @(negedge clk);
      if (n == 1) en1 = band_en;
      if (meas_valid) pulses++;
    end
    tests++; if (en1 !== 5'b00000) begin fails++; $display("FAIL both_break: got %b expected 00000", en1); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL both_pulses: got %0d expected 1", pulses); end
    tests++; if (band_en !== 5'b01000 || cur_band !== 3'd3) begin fails++; $display("FAIL both_band: got en=%b cur=%0d expected 01000/3", band_en, cur_band); end
  endtask

  task automatic test_meas_req();
    int mv_n;
    logic [NB-1:0] en1;
    mv_n = 0;
    en1 = '0;
    accept(3'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (n == 1) en1 = band_en;
      if (meas_valid) begin mv_n = n; break; end
    end
    tests++; if (en1 !== 5'b01000) begin fails++; $display("FAIL meas_band_en: got %b expected 01000", en1); end
    tests++; if (mv_n !== 1025) begin fails++; $display("FAIL meas_latency: got %0d expected 1025", mv_n); end
    tests++; if (meas_count < 8'd127 || meas_count > 8'd129) begin fails++; $display("FAIL meas_count: got %0d expected 128+-1", meas_count); end
  endtask

  task automatic test_reset_mid_measure();
    int mv_n;
    mv_n = 0;
    accept(3'd0, 1'b0, 1'b1);
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (band_en !== 5'b00001 || cur_band !== 3'd0) begin fails++; $display("FAIL rst_mid_band: got en=%b cur=%0d expected 00001/0", band_en, cur_band); end
    tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_ready: got ready=%b busy=%b expected 1/0", req_ready, busy); end
    tests++; if (meas_count !== 8'd0 || meas_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_count: got %0d/%b expected 0/0", meas_count, meas_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    vco_half = 2;
    @(negedge clk);
    accept(3'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (meas_valid) begin mv_n = n; break; end
    end
    tests++; if (mv_n !== 1025) begin fails++; $display("FAIL sat_latency: got %0d expected 1025", mv_n); end
    tests++; if (meas_count !== 8'd255) begin fails++; $display("FAIL sat_count: got %0d expected 255", meas_count); end
  endtask

  initial begin
    test_reset();
    test_switch_band2();
    test_same_band();
    test_illegal();
    test_req_and_meas();
    test_meas_req();
    test_reset_mid_measure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
